// File: rtl/sram_march_tester.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_tester
// Purpose  : Built-in self-test master for the SRAM path. Drives an Avalon-MM
//            slave with a four-element March test (up W0; up R0/W1;
//            down R1/W0; up R0) and reports pass/fail with the first failure.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_tester #(
  parameter int                ADDR_W     = 18,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] PATTERN    = 16'hA5A5,
  parameter int                LAST_ADDR  = 2**ADDR_W-1,
  parameter int                RD_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_exp_o,
  output logic [DATA_W-1:0] err_got_o,
  output logic [ADDR_W-1:0] amm_address_o,
  output logic              amm_read_o,
  output logic              amm_write_o,
  output logic [DATA_W-1:0] amm_writedata_o,
  input  logic [DATA_W-1:0] amm_readdata_i,
  input  logic              amm_readdatavalid_i,
  input  logic              amm_waitrequest_i
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LAST_ADDR);
  localparam int                c_cnt_w     = $clog2(RD_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_tmo      = c_cnt_w'(RD_TIMEOUT);
  localparam logic [DATA_W-1:0] c_pat0      = PATTERN;
  localparam logic [DATA_W-1:0] c_pat1      = ~PATTERN;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_write   = 3'd1;
  localparam logic [2:0] c_st_read    = 3'd2;
  localparam logic [2:0] c_st_wait_rd = 3'd3;
  localparam logic [2:0] c_st_advance = 3'd4;
  localparam logic [2:0] c_st_finish  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [1:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   err_exp_q, err_exp_d;
  logic [DATA_W-1:0]   err_got_q, err_got_d;

  // Element-dependent constants: element 2 runs downward and expects ~P,
  // element 1 writes ~P, everything else uses the background word P.
  logic              w_desc;
  logic              w_elem_end;
  logic [DATA_W-1:0] w_exp;
  logic [DATA_W-1:0] w_wdata;

  assign w_desc     = (elem_q == 2'd2);
  assign w_elem_end = w_desc ? (addr_q == '0) : (addr_q == c_last_addr);
  assign w_exp      = (elem_q == 2'd2) ? c_pat1 : c_pat0;
  assign w_wdata    = (elem_q == 2'd1) ? c_pat1 : c_pat0;

  // State and datapath registers; reset drops any request immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= c_st_idle;
      elem_q     <= 2'd0;
      addr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  // Next-state logic: march sequencing, read checking and result capture.
  // Entering FINISH clears busy and sets done together so both flip on the
  // same cycle.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    case (state_q)
      c_st_idle: begin
        if (start_i) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
          elem_d     = 2'd0;
          addr_d     = '0;
          state_d    = c_st_write;
        end
      end
      c_st_write: begin
        if (!amm_waitrequest_i) state_d = c_st_advance;
      end
      c_st_read: begin
        if (!amm_waitrequest_i) begin
          cnt_d   = '0;
          state_d = c_st_wait_rd;
        end
      end
      c_st_wait_rd: begin
        if (amm_readdatavalid_i) begin
          if (amm_readdata_i == w_exp) begin
            state_d = (elem_q == 2'd3) ? c_st_advance : c_st_write;
          end else begin
            err_addr_d = addr_q;
            err_exp_d  = w_exp;
            err_got_d  = amm_readdata_i;
            pass_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = c_st_finish;
          end
        end else if (cnt_q == c_tmo) begin
          timeout_d  = 1'b1;
          err_addr_d = addr_q;
          err_exp_d  = w_exp;
          err_got_d  = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = c_st_finish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_st_advance: begin
        if (w_elem_end) begin
          if (elem_q == 2'd3) begin
            pass_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = c_st_finish;
          end else begin
            // Elements 1..3 all open with a read; only element 2 starts high.
            elem_d  = elem_q + 2'd1;
            addr_d  = (elem_q == 2'd1) ? c_last_addr : '0;
            state_d = c_st_read;
          end
        end else begin
          addr_d  = w_desc ? (addr_q - 1'b1) : (addr_q + 1'b1);
          state_d = (elem_q == 2'd0) ? c_st_write : c_st_read;
        end
      end
      c_st_finish: state_d = c_st_idle;
      default:     state_d = c_st_idle;
    endcase
  end

  // Output decode: bus strobes follow the state directly, so they are held
  // through waitrequest and vanish as soon as reset clears the state.
  always_comb begin
    busy_o          = busy_q;
    done_o          = done_q;
    pass_o          = pass_q;
    timeout_o       = timeout_q;
    err_addr_o      = err_addr_q;
    err_exp_o       = err_exp_q;
    err_got_o       = err_got_q;
    amm_write_o     = (state_q == c_st_write);
    amm_read_o      = (state_q == c_st_read);
    amm_address_o   = '0;
    amm_writedata_o = '0;
    if ((state_q == c_st_write) || (state_q == c_st_read)) amm_address_o = addr_q;
    if (state_q == c_st_write) amm_writedata_o = w_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_tester
// Purpose  : Randomized self-checking bench for sram_march_tester with an
//            Avalon slave model and a list-based March reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_tester;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LAST = 15;
  localparam int TMO = 64;
  localparam logic [DW-1:0] P = 16'hA5A5;
  localparam int LIMIT = 6000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy, done, pass, tmo;
  logic [AW-1:0] err_addr, addr;
  logic [DW-1:0] err_exp, err_got, wdata, rdata;
  logic          rd, wr, rdv, waitreq;

  sram_march_tester #(
    .ADDR_W(AW), .DATA_W(DW), .PATTERN(P), .LAST_ADDR(LAST), .RD_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_addr_o(err_addr), .err_exp_o(err_exp), .err_got_o(err_got),
    .amm_address_o(addr), .amm_read_o(rd), .amm_write_o(wr),
    .amm_writedata_o(wdata), .amm_readdata_i(rdata),
    .amm_readdatavalid_i(rdv), .amm_waitrequest_i(waitreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the ordered list of transactions the March test must issue.
  typedef struct {bit we; int addr; logic [DW-1:0] data;} op_t;
  op_t exp_q[$];
  int  exp_pos;

  // Slave model configuration and state.
  int            fault_mode;   // 0 none, 1 corrupt read data, 2 drop readdatavalid
  int            fault_idx;
  logic [DW-1:0] bad_val;
  int            wprob;
  logic [DW-1:0] mem [0:LAST];
  int            rd_idx;
  bit            pend;
  int            lat;
  logic [DW-1:0] rdata_pend;
  bit            prev_stall;
  logic [AW+DW+1:0] prev_cmd;

  function automatic void push_op(bit we, int a, logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    exp_q.push_back(o);
  endfunction

  function automatic void build_march();
    exp_q.delete();
    for (int a = 0; a <= LAST; a++) push_op(1, a, P);
    for (int a = 0; a <= LAST; a++) begin push_op(0, a, P);  push_op(1, a, ~P); end
    for (int a = LAST; a >= 0; a--) begin push_op(0, a, ~P); push_op(1, a, P);  end
    for (int a = 0; a <= LAST; a++) push_op(0, a, P);
  endfunction

  task automatic accept_cmd();
    logic [AW+DW+1:0] got_v, exp_v;
    op_t e;
    chk("txn_in_range", exp_pos < exp_q.size(), 1);
    if (exp_pos < exp_q.size()) begin
      e = exp_q[exp_pos];
      if (e.we) begin
        got_v = {wr, rd, addr, wdata};
        exp_v = {1'b1, 1'b0, AW'(e.addr), e.data};
      end else begin
        got_v = {wr, rd, addr, 16'h0};
        exp_v = {1'b0, 1'b1, AW'(e.addr), 16'h0};
      end
      chk("txn", 64'(got_v), 64'(exp_v));
    end
    exp_pos++;
    if (int'(addr) <= LAST) begin
      if (wr) mem[addr] = wdata;
      else begin
        rdata_pend = mem[addr];
        if (fault_mode == 1 && rd_idx == fault_idx) rdata_pend = bad_val;
        pend = !(fault_mode == 2 && rd_idx == fault_idx);
        lat = $urandom_range(1, 3);
        rd_idx++;
      end
    end
  endtask

  // Avalon slave: samples requests mid-cycle, updates its drives just after
  // the rising edge.
  initial begin
    waitreq = 1'b0; rdv = 1'b0; rdata = '0;
    pend = 0; prev_stall = 0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        prev_stall = 0;
      end else begin
        if (rd || wr) chk("rd_wr_excl", {rd, wr}, {rd, 1'b0} | {1'b0, wr & ~rd});
        if (prev_stall) chk("stall_hold", 64'({rd, wr, addr, wdata}), 64'(prev_cmd));
        if ((rd || wr) && !waitreq) accept_cmd();
        prev_stall = (rd || wr) && waitreq;
        prev_cmd   = {rd, wr, addr, wdata};
      end
      @(posedge clk);
      #1;
      rdv   = 1'b0;
      rdata = DW'($urandom);
      if (pend && rst_n) begin
        lat--;
        if (lat == 0) begin
          rdv = 1'b1;
          rdata = rdata_pend;
          pend = 0;
        end
      end
      waitreq = ($urandom_range(0, 99) < wprob);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
  endtask

  // mode: 0 pass, 1 corrupt read #fidx with badv, 2 drop readdatavalid of read #fidx
  task automatic run_march(input int mode, input int fidx, input logic [DW-1:0] badv,
                           input int wp, input bit bump);
    int            n_exp, r;
    int            e_addr;
    logic [DW-1:0] e_exp;
    bit            got_done;
    build_march();
    e_addr = 0; e_exp = '0; r = 0;
    if (mode != 0) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (!exp_q[i].we) begin
          if (r == fidx) begin
            e_addr = exp_q[i].addr;
            e_exp  = exp_q[i].data;
            while (exp_q.size() > i + 1) void'(exp_q.pop_back());
            break;
          end
          r++;
        end
      end
    end
    n_exp = exp_q.size();
    for (int i = 0; i <= LAST; i++) mem[i] = DW'($urandom);
    exp_pos = 0; rd_idx = 0;
    fault_mode = mode; fault_idx = fidx; bad_val = badv; wprob = wp;
    pulse_start();
    got_done = 0;
    for (int c = 0; c < LIMIT && !got_done; c++) begin
      @(negedge clk);
      start = (bump && c == 40);
      if (done) got_done = 1;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("busy_low_at_done", busy, 0);
    chk("pass", pass, (mode == 0));
    chk("timeout", tmo, (mode == 2));
    chk("err_addr", err_addr, (mode == 0) ? 0 : e_addr);
    chk("err_exp", err_exp, (mode == 0) ? 0 : e_exp);
    chk("err_got", err_got, (mode == 1) ? badv : 0);
    chk("txn_count", exp_pos, n_exp);
    repeat (10) @(negedge clk);
    chk("txn_count_after", exp_pos, n_exp);
    chk("done_held", {done, pass}, {1'b1, mode == 0});
  endtask

  initial begin
    int            fi;
    logic [DW-1:0] bv;
    bit            hit;
    rst_n = 1'b0; start = 1'b0;
    fault_mode = 0; fault_idx = 0; bad_val = '0; wprob = 0;
    exp_pos = 0; rd_idx = 0;
    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, pass, tmo, err_addr, err_exp, err_got}, 0);
    chk("reset_bus", {addr, rd, wr, wdata}, 0);
    rst_n = 1'b1;

    // Ideal-ish slave, full pass.
    run_march(0, 0, '0, 0, 0);
    // Element 2, address 7 returns zero instead of ~P.
    run_march(1, 24, 16'h0000, 0, 0);
    // Heavy waitrequest stalling, plus a start pulse while busy.
    run_march(0, 0, '0, 60, 1);
    // Element 1, address 3 never answers.
    run_march(2, 3, '0, 0, 0);

    // Reset while a write is on the bus during element 1.
    build_march();
    exp_pos = 0; rd_idx = 0; fault_mode = 0; wprob = 30;
    pulse_start();
    hit = 0;
    for (int c = 0; c < LIMIT && !hit; c++) begin
      @(negedge clk);
      if (exp_pos >= 20 && wr) hit = 1;
    end
    chk("reset_point_seen", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_status", {busy, done, pass, tmo, err_addr, err_exp, err_got}, 0);
    chk("async_reset_bus", {addr, rd, wr, wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_march(0, 0, '0, 20, 0);

    // Random corruptions at random reads with random stalling.
    for (int k = 0; k < 4; k++) begin
      fi = $urandom_range(0, 3 * (LAST + 1) - 1);
      bv = DW'($urandom);
      if (fi < LAST + 1 || fi >= 2 * (LAST + 1)) begin
        if (bv == P) bv = ~bv;
      end else if (bv == ~P) bv = ~bv;
      run_march(1, fi, bv, $urandom_range(0, 50), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
